// File: rtl/sram_like_slave.sv
// sram_like_slave: responder end of the SRAM-like req/addr_ok, data_ok/rdata
// protocol. Accepted requests are performed on an external single-port
// synchronous RAM (1-cycle read latency) and answered strictly in order
// through a bounded return FIFO.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, wr, size, wen    address phase: valid, write flag, size (unused), byte strobes
//   addr, wdata           byte address, write data
//   addr_ok               request accepted this cycle when req && addr_ok
//   data_ok, rdata        one in-order response per accepted request
//   resp_hold             forces data_ok low while set (stall injection)
//   ram_en, ram_wen       backing RAM enable and byte write enables
//   ram_addr, ram_wdata   backing RAM word address and write data
//   ram_rdata             backing RAM read data, valid the cycle after ram_en
module sram_like_slave #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wen,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  input  logic              resp_hold,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] fifo_used;
  logic             fifo_empty;
  logic             accept;
  logic             pend_valid;
  logic             pend_wr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      fifo_q [DEPTH];

  // cnt covers the pending stage plus FIFO entries, so the FIFO alone
  // holds cnt minus the pending flag.
  assign fifo_used  = cnt - CNT_W'(pend_valid);
  assign fifo_empty = (fifo_used == '0);

  // Address phase: credit depends only on registered cnt, never on req.
  assign addr_ok = !reset && (cnt < CNT_W'(DEPTH));
  assign accept  = req && addr_ok;

  // RAM is driven directly in the accept cycle; the write lands at its end.
  always_comb begin
    ram_en    = accept;
    ram_wen   = (accept && wr) ? wen : 4'b0000;
    ram_addr  = addr[ADDR_W+1:2];
    ram_wdata = wdata;
  end

  // Data phase: head of the return FIFO, suppressed by resp_hold.
  always_comb begin
    data_ok = !reset && !fifo_empty && !resp_hold;
    rdata   = data_ok ? fifo_q[rd_ptr] : 32'h0;
  end

  // Outstanding count: +1 on accept, -1 on retire.
  always_comb begin
    cnt_nxt = cnt;
    case ({accept, data_ok})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Control state: counter, pending stage, FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      cnt        <= cnt_nxt;
      pend_valid <= accept;
      pend_wr    <= wr;
      if (pend_valid) wr_ptr <= wr_ptr + PTR_W'(1);
      if (data_ok)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Return FIFO storage; writes answer with zero data.
  always_ff @(posedge clk) begin
    if (!reset && pend_valid) begin
      fifo_q[wr_ptr] <= pend_wr ? 32'h0 : ram_rdata;
    end
  end

  // Address bits outside the word index and the size field carry no function.
  logic unused_hi;
  generate
    if (ADDR_W + 2 < 32) begin : g_hi
      assign unused_hi = ^addr[31:ADDR_W+2];
    end else begin : g_no_hi
      assign unused_hi = 1'b0;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{size, addr[1:0], unused_hi};

endmodule
